// File: rtl/fifo_pkg.sv
// Shared FIFO types, defaults and the count-width helper.
// Imported by fifo_if, fifo_mem and fifo_ctrl.
package fifo_pkg;

    localparam int DEF_B         = 8;
    localparam int DEF_W         = 4;
    localparam int DEF_AEMPTY_TH = 1;

    // Occupancy needs one extra bit so that 0..D fits.
    function automatic int cnt_w(input int w);
        return w + 1;
    endfunction

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
    } flags_t;

    localparam flags_t FLAGS_RST = '{
        empty:        1'b1,
        full:         1'b0,
        almost_empty: 1'b1,
        almost_full:  1'b0
    };

endpackage

// File: rtl/fifo_if.sv
// FIFO request/response bundle.
// master: wr, w_data, rd, clr_err out; data, flags, count, errors in.
// slave : the mirror image, used by fifo_ctrl.
interface fifo_if
    import fifo_pkg::*;
#(
    parameter int B = DEF_B,
    parameter int W = DEF_W
);
    logic                   wr;
    logic [B-1:0]           w_data;
    logic                   rd;
    logic [B-1:0]           r_data;
    logic                   r_valid;
    logic                   empty;
    logic                   full;
    logic                   almost_empty;
    logic                   almost_full;
    logic [cnt_w(W)-1:0]    count;
    logic                   overflow;
    logic                   underflow;
    logic                   clr_err;

    modport master (
        output wr, w_data, rd, clr_err,
        input  r_data, r_valid, empty, full,
        input  almost_empty, almost_full, count,
        input  overflow, underflow
    );

    modport slave (
        input  wr, w_data, rd, clr_err,
        output r_data, r_valid, empty, full,
        output almost_empty, almost_full, count,
        output overflow, underflow
    );
endinterface

// File: rtl/fifo_mem.sv
// FIFO storage: B x 2**W register array, one write port,
// one asynchronous read port. Contents are never reset.
// Ports: clk, we, waddr, wdata, raddr, rdata.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int B = DEF_B,
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         we,
    input  logic [W-1:0] waddr,
    input  logic [B-1:0] wdata,
    input  logic [W-1:0] raddr,
    output logic [B-1:0] rdata
);
    logic [B-1:0] mem [2**W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller: pointers, occupancy, status and
// sticky error flags, read register. Optional macro FIFO_FWFT_EN
// selects first-word-fall-through reads; default is registered.
// Ports: clk, reset_n (sync, active-low), bus (fifo_if.slave).
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int B         = DEF_B,
    parameter int W         = DEF_W,
    parameter int AFULL_TH  = 2**W - 1,
    parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
    input  logic   clk,
    input  logic   reset_n,
    fifo_if.slave  bus
);
    localparam int CW = cnt_w(W);
    localparam int D  = 2**W;

    logic [W-1:0]  wptr;
    logic [W-1:0]  rptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    flags_t        flags;
    flags_t        flags_nxt;
    logic          overflow;
    logic          underflow;
    logic          wr_ok;
    logic          rd_ok;
    logic [B-1:0]  head;

    // A write into a full FIFO is fine when a pop frees the slot
    // in the same cycle.
    assign rd_ok = bus.rd & ~flags.empty;
    assign wr_ok = bus.wr & (~flags.full | bus.rd);

    always_comb begin
        count_nxt = count;
        if (wr_ok && !rd_ok) begin
            count_nxt = count + CW'(1);
        end else if (!wr_ok && rd_ok) begin
            count_nxt = count - CW'(1);
        end
    end

    always_comb begin
        flags_nxt              = FLAGS_RST;
        flags_nxt.empty        = (count_nxt == CW'(0));
        flags_nxt.full         = (count_nxt == CW'(D));
        flags_nxt.almost_empty = (count_nxt <= CW'(AEMPTY_TH));
        flags_nxt.almost_full  = (count_nxt >= CW'(AFULL_TH));
    end

    fifo_mem #(
        .B (B),
        .W (W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wptr),
        .wdata (bus.w_data),
        .raddr (rptr),
        .rdata (head)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            flags     <= FLAGS_RST;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + W'(1);
            end
            if (rd_ok) begin
                rptr <= rptr + W'(1);
            end
            count <= count_nxt;
            flags <= flags_nxt;
            // Setting beats clearing within one cycle.
            overflow  <= (bus.wr & flags.full & ~bus.rd)
                       | (overflow & ~bus.clr_err);
            underflow <= (bus.rd & flags.empty)
                       | (underflow & ~bus.clr_err);
        end
    end

`ifdef FIFO_FWFT_EN
    assign bus.r_data  = head;
    assign bus.r_valid = ~flags.empty;
`else
    logic [B-1:0] r_data_q;
    logic         r_valid_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
        end else begin
            r_valid_q <= rd_ok;
            if (rd_ok) begin
                r_data_q <= head;
            end
        end
    end

    assign bus.r_data  = r_data_q;
    assign bus.r_valid = r_valid_q;
`endif

    assign bus.count        = count;
    assign bus.empty        = flags.empty;
    assign bus.full         = flags.full;
    assign bus.almost_empty = flags.almost_empty;
    assign bus.almost_full  = flags.almost_full;
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;
endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter B, default 8: data word width in bits, 1..64.
REQ-002 Parameter W, default 4: address bits; depth D = 2**W, W 1..10.
REQ-003 Parameter AFULL_TH, default 2**W-1: almost_full threshold, 1..D.
REQ-004 Parameter AEMPTY_TH, default 1: almost_empty threshold, 0..D-1.
REQ-005 clk  in  1  sole clock, all state updates on rising edge.
REQ-006 reset_n  in  1  reset, synchronous, active-low.
REQ-007 wr  in  1  write request; w_data  in  B  write word.
REQ-008 rd  in  1  read/pop request.
REQ-009 r_data  out  B  read word; r_valid  out  1  r_data qualifier.
REQ-010 empty, full, almost_empty, almost_full  out  1 each  registered status flags.
REQ-011 count  out  W+1  registered occupancy, 0..D.
REQ-012 overflow, underflow  out  1 each  sticky error flags; clr_err  in  1  clears both.

Function
REQ-013 Write accepted when wr & (~full | rd); word stored at write pointer, pointer +1 modulo D.
REQ-014 Read accepted when rd & ~empty; read pointer +1 modulo D.
REQ-015 wr & rd while empty: only the write is accepted; count -> 1; underflow set.
REQ-016 wr & rd while full: both accepted; count stays D, full stays 1.
REQ-017 wr & rd otherwise: both accepted; count unchanged.
REQ-018 count +1 on write-only, -1 on read-only, never outside 0..D.
REQ-019 Flags are registered and derive from next count: empty = (count==0), full = (count==D), almost_full = (count>=AFULL_TH), almost_empty = (count<=AEMPTY_TH).
REQ-020 overflow set on wr & full & ~rd; underflow set on rd & empty; both remain set until clr_err.
REQ-021 clr_err clears both error flags; a set condition in the same cycle wins.
REQ-022 Pointer wrap from D-1 to 0 carries no side effect on flags or data.

Reset
REQ-023 reset_n low at a clock edge: pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0, r_valid 0, r_data 0.
REQ-024 reset_n has priority over wr, rd and clr_err; in-flight requests in that cycle are discarded.
REQ-025 Storage array is not reset; contents are unobservable until written.

Configuration
REQ-026 Macro FIFO_FWFT_EN defined: first-word-fall-through; r_data shows the head word combinationally, r_valid = ~empty, rd pops the shown word.
REQ-027 FIFO_FWFT_EN undefined: registered read; an accepted read loads r_data on the next edge with r_valid high for exactly that one cycle; r_data holds its value otherwise.
REQ-028 All other behaviour is identical in both builds.

Structure
REQ-029 Package fifo_pkg holds the count-width helper (W+1) and shared flag/threshold constants.
REQ-030 Storage is sub-module fifo_mem: B x D register array, one write port, one asynchronous read port; fifo_ctrl holds pointers, count, flags and the read register.

Verification (B=8, W=2, AFULL_TH=3, AEMPTY_TH=1)
REQ-031 Reset, then write 0x11,0x22,0x33,0x44 -> count 1,2,3,4; almost_empty drops at count 2; almost_full rises at 3; full at 4.
REQ-032 From full, wr 0x55 without rd -> data ignored, count 4, overflow 1; clr_err -> overflow 0.
REQ-033 From full, wr 0x55 & rd together -> 0x11 read, count 4; drain yields 0x22,0x33,0x44,0x55 (pointer wrap).
REQ-034 Empty, wr 0xA5 & rd together -> count 1, underflow 1, next read returns 0xA5.
REQ-035 Registered build: rd with head 0x11 -> r_data 0x11, r_valid high one cycle later for one cycle; FWFT build: r_data 0x11 while empty=0, before rd.
REQ-036 reset_n low with count 3 and wr asserted -> next cycle count 0, empty 1, all errors 0.
